// File: rtl/mem_sub_unit_arbiter.sv
// Round-robin arbiter sharing one memory sub-unit among NUM_REQ requesters, with in-order read-return routing.
// Latency: requests forward to the responder in the same cycle; read data returns to its owner in the same cycle it arrives.
// Backpressure: req_ready falls when mem_ready is low or MAX_INFLIGHT reads are outstanding; a same-cycle return does not lift full.
module mem_sub_unit_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_new_request,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_data_in,
  input  logic [NUM_REQ-1:0]     req_re,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [NUM_REQ*4-1:0]   req_be,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     req_data_valid,
  output logic [31:0]            req_data_out,
  output logic                   mem_new_request,
  output logic                   mem_re,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_data_in,
  output logic [3:0]             mem_be,
  input  logic                   mem_ready,
  input  logic                   mem_data_valid,
  input  logic [31:0]            mem_data_out,
  output logic                   idle,
  output logic                   protocol_error
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_INFLIGHT);

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          protocol_error_q, protocol_error_d;
  logic [PW-1:0] owner_q [MAX_INFLIGHT];
  logic [PW-1:0] owner_d [MAX_INFLIGHT];

  logic          full;
  logic          can_accept;
  logic          grant_vld;
  logic [PW-1:0] grant_idx;
  logic          push;
  logic          pop;

  assign full       = (count_q == FULL_CNT);
  assign can_accept = mem_ready & ~full;

  // Walk requesters in round-robin order from rr_ptr; each one is ready only if nobody ahead of it is strobing.
  always_comb begin
    logic          blocked;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    req_ready = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    blocked   = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
      idx = sum[PW-1:0];
      req_ready[idx] = can_accept & ~blocked;
      if (req_new_request[idx] && can_accept && !blocked) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
      blocked = blocked | req_new_request[idx];
    end
  end

  // Forward the winner's fields straight through to the responder; outputs are zero when nothing is granted.
  always_comb begin
    mem_new_request = grant_vld;
    mem_re          = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_data_in     = '0;
    mem_be          = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vld && grant_idx == PW'(i)) begin
        mem_re      = req_re[i];
        mem_we      = req_we[i];
        mem_addr    = req_addr[i*32 +: 32];
        mem_data_in = req_data_in[i*32 +: 32];
        mem_be      = req_be[i*4 +: 4];
      end
    end
  end

  // Return routing: the FIFO head names the owner of the data arriving now; a return with nothing outstanding is an error.
  always_comb begin
    pop            = mem_data_valid && (count_q != '0);
    req_data_valid = '0;
    if (pop) req_data_valid[owner_q[rd_ptr_q]] = 1'b1;
    req_data_out   = mem_data_out;
    idle           = (count_q == '0);
    protocol_error = protocol_error_q;
  end

  // Next-state: pointer advance, owner FIFO push/pop (read-and-write requests count as reads), sticky error.
  always_comb begin
    push             = grant_vld & mem_re;
    rr_ptr_d         = rr_ptr_q;
    count_d          = count_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    owner_d          = owner_q;
    protocol_error_d = protocol_error_q | (mem_data_valid & (count_q == '0));
    if (grant_vld) begin
      if (grant_idx == PW'(NUM_REQ - 1)) rr_ptr_d = '0;
      else                               rr_ptr_d = grant_idx + PW'(1);
    end
    if (push) begin
      owner_d[wr_ptr_q] = grant_idx;
      wr_ptr_d          = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Control state with synchronous active-low reset; reset drops every outstanding owner entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q         <= '0;
      count_q          <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      count_q          <= count_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  // Owner storage needs no reset: entries are only read below the registered count.
  always_ff @(posedge clk) begin
    owner_q <= owner_d;
  end

endmodule
